// File: rtl/waveform_player_bram_if.sv
// Host pipe and playback control/status bundle for waveform_player_bram.
// The host/controller side uses the master modport; the player uses slave.
interface waveform_player_bram_if #(
    parameter int ADDR_W   = 11,
    parameter int SAMPLE_W = 32
);
    // Host pipe
    logic                pipe_in_write;
    logic [15:0]         pipe_in_data;
    logic                pipe_out_read;
    logic [15:0]         pipe_out_data;
    logic                pipe_addr_clr;
    // Playback control and status
    logic [ADDR_W:0]     length;
    logic                loop_mode;
    logic                start;
    logic                stop;
    logic                pop;
    logic [SAMPLE_W-1:0] wave;
    logic                wave_valid;
    logic                busy;
    logic                done;

    modport master (
        output pipe_in_write, pipe_in_data, pipe_out_read, pipe_addr_clr,
        output length, loop_mode, start, stop, pop,
        input  pipe_out_data, wave, wave_valid, busy, done
    );

    modport slave (
        input  pipe_in_write, pipe_in_data, pipe_out_read, pipe_addr_clr,
        input  length, loop_mode, start, stop, pop,
        output pipe_out_data, wave, wave_valid, busy, done
    );
endinterface

// File: rtl/waveform_player_bram.sv
// Pipe-loaded waveform buffer: 16-bit host words are packed little-endian into
// SAMPLE_W-bit samples held in a dual-port block RAM, and a playback engine
// steps through the first L samples on each pop, one-shot or looping.
// SAMPLE_W must be a multiple of 16 in the range 16..64.
module waveform_player_bram #(
    parameter int ADDR_W   = 11,
    parameter int SAMPLE_W = 32
) (
    input  logic clk,
    input  logic reset,
    waveform_player_bram_if.slave bus
);
    localparam int WPS   = SAMPLE_W / 16;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int KW    = (WPS > 1) ? $clog2(WPS) : 1;
    localparam logic [KW-1:0]   K_LAST    = KW'(WPS - 1);
    localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    logic [SAMPLE_W-1:0] ram [DEPTH];

    // Word address is kept as (sample index, word-in-sample) so depths with
    // WPS=3 wrap correctly without a divider.
    logic [ADDR_W-1:0]   sample_idx_reg;
    logic [KW-1:0]       word_idx_reg;
    logic [SAMPLE_W-1:0] commit_data;
    logic                pipe_access;
    logic                commit;

    logic [15:0]         pipe_out_reg;
    logic [SAMPLE_W-1:0] wave_reg;
    logic                wave_valid_reg;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   pop_addr_reg;
    logic [ADDR_W:0]     len_reg;
    logic                loop_reg;
    logic [ADDR_W:0]     len_eff;
    logic                start_go;
    logic                pop_fire;
    logic                last;

    assign pipe_access = bus.pipe_in_write | bus.pipe_out_read;
    assign commit      = bus.pipe_in_write && !bus.pipe_addr_clr && (word_idx_reg == K_LAST);

    // Packer: every slice but the last is buffered; the last slice comes
    // straight from the pipe so the full sample commits on its final word.
    for (genvar gi = 0; gi < WPS; gi++) begin : g_slice
        if (gi == WPS - 1) begin : g_last
            assign commit_data[16*gi +: 16] = bus.pipe_in_data;
        end else begin : g_pack
            logic [15:0] slice_reg;
            // Capture word gi of the sample currently being assembled
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    slice_reg <= '0;
                else if (bus.pipe_addr_clr)
                    slice_reg <= '0;
                else if (bus.pipe_in_write && word_idx_reg == KW'(gi))
                    slice_reg <= bus.pipe_in_data;
            end
            assign commit_data[16*gi +: 16] = slice_reg;
        end
    end

    // Pipe word address: one step per read/write strobe, clear wins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_idx_reg <= '0;
            word_idx_reg   <= '0;
        end else if (bus.pipe_addr_clr) begin
            sample_idx_reg <= '0;
            word_idx_reg   <= '0;
        end else if (pipe_access) begin
            if (word_idx_reg == K_LAST) begin
                word_idx_reg   <= '0;
                sample_idx_reg <= sample_idx_reg + 1'b1;
            end else begin
                word_idx_reg   <= word_idx_reg + 1'b1;
            end
        end
    end

    // Port A write: commit a completed sample (RAM contents survive reset)
    always_ff @(posedge clk) begin
        if (commit)
            ram[sample_idx_reg] <= commit_data;
    end

    // Port A read: registered readback of the addressed word, read-first
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pipe_out_reg <= '0;
        else if (bus.pipe_out_read && !bus.pipe_addr_clr)
            pipe_out_reg <= ram[sample_idx_reg][16*word_idx_reg +: 16];
    end

    // Lengths beyond the buffer play the whole buffer
    assign len_eff  = (bus.length > DEPTH_LEN) ? DEPTH_LEN : bus.length;
    assign start_go = bus.start && !bus.stop && (len_eff != '0);
    assign pop_fire = (state_reg == S_RUN) && bus.pop && !bus.stop && !start_go;
    assign last     = (pop_addr_reg == ADDR_W'(len_reg - 1'b1));

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    // FSM next state: stop beats start, start beats pop
    always_comb begin
        state_next = state_reg;
        if (bus.stop)
            state_next = S_IDLE;
        else if (start_go)
            state_next = S_RUN;
        else if (pop_fire && last && !loop_reg)
            state_next = S_DONE;
    end

    // FSM outputs
    always_comb begin
        bus.busy = (state_reg == S_RUN);
        bus.done = (state_reg == S_DONE);
    end

    // Playback pointer and latched region settings
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pop_addr_reg   <= '0;
            len_reg        <= '0;
            loop_reg       <= 1'b0;
            wave_valid_reg <= 1'b0;
        end else begin
            wave_valid_reg <= pop_fire;
            if (bus.stop) begin
                pop_addr_reg <= '0;
            end else if (start_go) begin
                pop_addr_reg <= '0;
                len_reg      <= len_eff;
                loop_reg     <= bus.loop_mode;
            end else if (pop_fire) begin
                pop_addr_reg <= last ? '0 : pop_addr_reg + 1'b1;
            end
        end
    end

    // Port B read: wave follows its pop by one cycle, read-first on collision
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wave_reg <= '0;
        else if (pop_fire)
            wave_reg <= ram[pop_addr_reg];
    end

    assign bus.pipe_out_data = pipe_out_reg;
    assign bus.wave          = wave_reg;
    assign bus.wave_valid    = wave_valid_reg;
endmodule

// File: doc/waveform_player_bram.md
Name: waveform_player_bram

Overview:
- Parametrised single-clock successor to the pipe-loaded waveform buffers. A host writes 16-bit pipe words, which are packed into SAMPLE_W-bit samples in an inferred dual-port block RAM.
- A playback engine steps through a programmable-length region on a pop strobe, in one-shot or loop mode.
- Sits between the host pipe endpoints and the stimulus datapath (e.g. spindle/motor-neuron drive). Replaces the free-running, fixed-depth, dual-clock variants.

Parameters:
- ADDR_W, 11, log2 of sample depth (DEPTH = 2^ADDR_W samples).
- SAMPLE_W, 32, sample width. Must be a multiple of 16, with range 16..64.
- WPS (derived), SAMPLE_W/16, pipe words per sample.

Ports:
- clk  in  1  sole clock (pipe and playback).
- reset  in  1  asynchronous, active-low reset.
- pipe_in_write  in  1  write strobe for pipe_in_data.
- pipe_in_data  in  16  pipe word.
- pipe_out_read  in  1  readback strobe.
- pipe_out_data  out  16  readback word.
- pipe_addr_clr  in  1  synchronous clear of the pipe word address and the packer.
- length  in  ADDR_W+1  playback length in samples. Values above DEPTH clamp to DEPTH.
- loop_mode  in  1  1 = wrap, 0 = one-shot. Sampled at start.
- start  in  1  begin or restart playback at sample 0.
- stop  in  1  abort to IDLE.
- pop  in  1  advance strobe (one sample per asserted cycle).
- wave  out  SAMPLE_W  current sample.
- wave_valid  out  1  one-cycle pulse when wave updates.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.

Behaviour:

Reset:
- Asynchronous, active-low, with deassertion applied on clk.
- On reset: wave=0, wave_valid=0, busy=0, done=0, pipe_out_data=0, pipe word address=0, packer cleared, pop_addr=0, FSM=IDLE.
- RAM contents are not cleared.

Pipe write:
- The word address counts 0..DEPTH*WPS-1 and wraps to 0.
- It increments on pipe_in_write or pipe_out_read; simultaneous assertion counts once.
- Word k of a sample (k = addr mod WPS) lands in bits [16k+15:16k], little-endian.
- Words 0..WPS-2 are held in a packer register. On word WPS-1, the full sample is written to RAM at addr/WPS in the same cycle.
- A partially packed sample is never written.
- pipe_addr_clr has priority over a coincident strobe: the address goes to 0, the packer clears, and that strobe's write is dropped.

Pipe read:
- pipe_out_data registers, one cycle after pipe_out_read, slice k of the sample at the pre-increment address.
- If that sample is not yet committed, RAM content is returned, not packer content.
- pipe_out_data holds between reads.

FSM (IDLE, RUN, DONE):
- start with effective length L=0 is ignored and the FSM stays in its current state.
- start with L>0 from any state goes to RUN with pop_addr=0; loop_mode and L are latched.
- stop from any state goes to IDLE.
- start and stop together: stop wins.
- RUN + pop: wave <= RAM[pop_addr] at the next edge (1-cycle latency), and wave_valid pulses that same cycle.
- In RUN, if pop_addr == L-1: loop mode sets pop_addr=0 and stays in RUN; one-shot mode goes to DONE in the cycle wave shows the last sample.
- Otherwise pop_addr increments.
- pop in IDLE or DONE is ignored: wave holds and wave_valid stays 0.
- done stays high until start (L>0) or stop.
- wave is never cleared except by reset.

RAM collisions:
- Port A is pipe write/read; port B is playback read, read-first.
- A pipe commit to the sample popped in the same cycle returns the old data.
- Pipe traffic is legal in every FSM state.

Test Plan:
- ADDR_W=4, SAMPLE_W=32: write 8 words 0x0001..0x0008, then start with L=4, one-shot, and pop each cycle -> wave = 0x00020001, 0x00040003, 0x00060005, 0x00080007 on consecutive cycles, each 1 cycle after its pop; 4 wave_valid pulses; done=1 after the 4th; a 5th pop leaves wave at 0x00080007 with wave_valid=0.
- Same data, L=3, loop, 7 pops -> sample indices 0,1,2,0,1,2,0; busy stays 1; done stays 0.
- L=20 with DEPTH=16 and loop: 17 pops -> indices 0..15 then 0. L=0 start -> state stays IDLE, busy=0.
- Readback: pipe_addr_clr, then 3 pipe_out_read strobes -> pipe_out_data = 0x0001, 0x0002, 0x0003, each one cycle after its strobe.
- Write 1 word, then pipe_addr_clr, then write 0xAAAA, 0xBBBB -> sample 0 = 0xBBBBAAAA; the partial write never reaches RAM.
- Assert reset low asynchronously mid-RUN, between edges -> all outputs go to 0 immediately; after release, pop is ignored until start.
